// File: rtl/ascon_round_sequencer_pkg.sv
// Shared ASCON definitions for the round sequencer: state type, round constants,
// sequencer FSM encoding and round-index bounds.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } type_seq_state;

  localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
  localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  localparam logic [7:0] round_constant [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  function automatic logic [63:0] rotr64(input logic [63:0] v, input int unsigned n);
    logic [127:0] w_dbl;
    w_dbl = {v, v} >> n;
    return w_dbl[63:0];
  endfunction

endpackage

// File: rtl/ascon_round_sequencer_if.sv
// Request/result bundle between the ASCON mode FSM (master) and the round sequencer (slave).
interface ascon_round_sequencer_if;
  import ascon_pack::*;

  logic      start_i;
  logic      mode_i;
  type_state state_i;
  logic      ready_o;
  logic      valid_o;
  type_state state_o;
  logic [3:0] round_o;

  modport master (output start_i, mode_i, state_i,
                  input  ready_o, valid_o, state_o, round_o);
  modport slave  (input  start_i, mode_i, state_i,
                  output ready_o, valid_o, state_o, round_o);

endinterface

// File: rtl/ascon_round_sequencer_round.sv
// One ASCON round, purely combinational: constant addition, 5-bit S-box layer
// (bit-sliced), then the per-word linear diffusion.
module permutation_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  logic [7:0]  w_rc;
  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

  // Round function datapath
  always_comb begin
    w_rc = 8'h00;
    if (round_i <= ROUND_LAST) begin
      w_rc = round_constant[round_i];
    end else begin
      w_rc = 8'h00;
    end

    w_x0 = state_i[0];
    w_x1 = state_i[1];
    w_x2 = state_i[2] ^ {56'h0, w_rc};
    w_x3 = state_i[3];
    w_x4 = state_i[4];

    w_x0 = w_x0 ^ w_x4;
    w_x4 = w_x4 ^ w_x3;
    w_x2 = w_x2 ^ w_x1;
    w_t0 = ~w_x0 & w_x1;
    w_t1 = ~w_x1 & w_x2;
    w_t2 = ~w_x2 & w_x3;
    w_t3 = ~w_x3 & w_x4;
    w_t4 = ~w_x4 & w_x0;
    w_x0 = w_x0 ^ w_t1;
    w_x1 = w_x1 ^ w_t2;
    w_x2 = w_x2 ^ w_t3;
    w_x3 = w_x3 ^ w_t4;
    w_x4 = w_x4 ^ w_t0;
    w_x1 = w_x1 ^ w_x0;
    w_x0 = w_x0 ^ w_x4;
    w_x3 = w_x3 ^ w_x2;
    w_x2 = ~w_x2;

    state_o[0] = w_x0 ^ rotr64(w_x0, 19) ^ rotr64(w_x0, 28);
    state_o[1] = w_x1 ^ rotr64(w_x1, 61) ^ rotr64(w_x1, 39);
    state_o[2] = w_x2 ^ rotr64(w_x2, 1)  ^ rotr64(w_x2, 6);
    state_o[3] = w_x3 ^ rotr64(w_x3, 10) ^ rotr64(w_x3, 17);
    state_o[4] = w_x4 ^ rotr64(w_x4, 7)  ^ rotr64(w_x4, 41);
  end

endmodule

// File: rtl/ascon_round_sequencer.sv
// Iterative ASCON p^12 / p^6 engine: 320-bit state register stepped one round per clock.
// Optional build macro ASCON_UNROLL2_EN chains two round instances (two rounds per clock).
module ascon_round_sequencer
  import ascon_pack::*;
(
  input  logic                     clock_i,
  input  logic                     resetb_i,
  ascon_round_sequencer_if.slave   bus
);

  type_seq_state r_fsm;
  logic [3:0]    r_round_cnt;
  type_state     r_state;
  logic          r_ready;
  logic          r_valid;
  type_state     w_next;

`ifdef ASCON_UNROLL2_EN
  localparam logic [3:0] ROUND_STEP = 4'd2;
  localparam logic [3:0] ROUND_EXIT = ROUND_LAST - 4'd1;

  type_state  w_mid;
  logic [3:0] w_round_b;

  assign w_round_b = r_round_cnt + 4'd1;

  permutation_round u_round_a (.state_i(r_state), .round_i(r_round_cnt), .state_o(w_mid));
  permutation_round u_round_b (.state_i(w_mid),   .round_i(w_round_b),   .state_o(w_next));
`else
  localparam logic [3:0] ROUND_STEP = 4'd1;
  localparam logic [3:0] ROUND_EXIT = ROUND_LAST;

  permutation_round u_round_a (.state_i(r_state), .round_i(r_round_cnt), .state_o(w_next));
`endif

  // Sequencer FSM with registered handshake outputs; reset aborts any running permutation
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm       <= IDLE;
      r_round_cnt <= 4'd0;
      r_state     <= '0;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE, DONE: begin
          if (bus.start_i) begin
            r_state     <= bus.state_i;
            r_round_cnt <= bus.mode_i ? ROUND_FIRST_P6 : ROUND_FIRST_P12;
            r_fsm       <= RUN;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
          end
        end
        RUN: begin
          r_state <= w_next;
          if (r_round_cnt == ROUND_EXIT) begin
            r_fsm   <= DONE;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_round_cnt <= r_round_cnt + ROUND_STEP;
          end
        end
        default: begin
          r_fsm   <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.valid_o = r_valid;
  assign bus.state_o = r_state;
  assign bus.round_o = r_round_cnt;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Self-checking bench for ascon_round_sequencer against a table-driven ASCON permutation model.
module tb_ascon_round_sequencer;
  import ascon_pack::*;

`ifdef ASCON_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ascon_round_sequencer_if bus_if ();

  ascon_round_sequencer dut (
    .clock_i  (clk),
    .resetb_i (rstn),
    .bus      (bus_if)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference permutation: rounds first..11, S-box applied column by column via lookup table
  function automatic type_state ref_perm(input type_state s_in, input int first);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  v;
    type_state   s_out;
    for (int i = 0; i < 5; i++) x[i] = s_in[i];
    for (int r = first; r < 12; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        v = SBOX[col];
        for (int i = 0; i < 5; i++) y[i][b] = v[4 - i];
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ ror(y[i], ROT_A[i]) ^ ror(y[i], ROT_B[i]);
    end
    for (int i = 0; i < 5; i++) s_out[i] = x[i];
    return s_out;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction

  function automatic int lat_of(input logic m);
    return (m ? 6 : 12) / STEP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_accept(input type_state s, input logic m);
    bus_if.start_i = 1'b1;
    bus_if.mode_i  = m;
    bus_if.state_i = s;
    tick();
    bus_if.start_i = 1'b0;
    bus_if.mode_i  = 1'($urandom);
    bus_if.state_i = rand_state();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) tick();
    total++; if (bus_if.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus_if.ready_o); end
    total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus_if.valid_o); end
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (bus_if.ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready c=%0d got=%0b want=1", c, bus_if.ready_o); end
      total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL idle_valid c=%0d got=%0b want=0", c, bus_if.valid_o); end
      total++; if (bus_if.state_o !== 320'h0) begin bad++; $display("FAIL idle_state c=%0d got=%h want=0", c, bus_if.state_o); end
      total++; if (bus_if.round_o !== 4'd0) begin bad++; $display("FAIL idle_round c=%0d got=%0d want=0", c, bus_if.round_o); end
    end
  endtask

  task automatic test_p12_kat();
    type_state s, exp;
    int lat;
    s = '0;
    s[0] = 64'h80400c0600000000;
    exp = ref_perm(s, 0);
    lat = lat_of(1'b0);
    drive_accept(s, 1'b0);
    for (int j = 0; j < lat; j++) begin
      total++; if (bus_if.round_o !== 4'(j * STEP)) begin bad++; $display("FAIL p12_round j=%0d got=%0d want=%0d", j, bus_if.round_o, j * STEP); end
      total++; if ({bus_if.valid_o, bus_if.ready_o} !== 2'b00) begin bad++; $display("FAIL p12_busy j=%0d got=%b want=00", j, {bus_if.valid_o, bus_if.ready_o}); end
      tick();
    end
    total++; if ({bus_if.valid_o, bus_if.ready_o} !== 2'b11) begin bad++; $display("FAIL p12_done got=%b want=11", {bus_if.valid_o, bus_if.ready_o}); end
    total++; if (bus_if.state_o !== exp) begin bad++; $display("FAIL p12_state got=%h want=%h", bus_if.state_o, exp); end
    total++; if (bus_if.round_o !== 4'(12 - STEP)) begin bad++; $display("FAIL p12_last_round got=%0d want=%0d", bus_if.round_o, 12 - STEP); end
    repeat (2) tick();
    total++; if (bus_if.valid_o !== 1'b1 || bus_if.state_o !== exp) begin bad++; $display("FAIL p12_hold valid=%0b state=%h want=%h", bus_if.valid_o, bus_if.state_o, exp); end
  endtask

  task automatic test_p6();
    type_state s, exp;
    int lat;
    lat = lat_of(1'b1);
    for (int n = 0; n < 3; n++) begin
      s = rand_state();
      exp = ref_perm(s, 6);
      drive_accept(s, 1'b1);
      for (int j = 0; j < lat; j++) begin
        total++; if (bus_if.round_o !== 4'(6 + j * STEP)) begin bad++; $display("FAIL p6_round n=%0d j=%0d got=%0d want=%0d", n, j, bus_if.round_o, 6 + j * STEP); end
        total++; if (bus_if.valid_o !== 1'b0) begin bad++; $display("FAIL p6_early_valid n=%0d j=%0d got=1 want=0", n, j); end
        tick();
      end
      total++; if (bus_if.valid_o !== 1'b1) begin bad++; $display("FAIL p6_valid n=%0d got=0 want=1", n); end
      total++; if (bus_if.state_o !== exp) begin bad++; $display("FAIL p6_state n=%0d got=%h want=%h", n, bus_if.state_o, exp); end
    end
  endtask

  task automatic test_busy_start();
    type_state s, exp;
    int lat;
    s = rand_state();
    exp = ref_perm(s, 0);
    lat = lat_of(1'b0);
    drive_accept(s, 1'b0);
    for (int j = 0; j < lat; j++) begin
      total++; if (bus_if.round_o !== 4'(j * STEP)) begin bad++; $display("FAIL busy_round j=%0d got=%0d want=%0d", j, bus_if.round_o, j * STEP); end
      if (j * STEP == 4) begin
        bus_if.start_i = 1'b1;
        bus_if.mode_i  = 1'b1;
        bus_if.state_i = rand_state();
      end
      tick();
      bus_if.start_i = 1'b0;
    end
    total++; if (bus_if.valid_o !== 1'b1) begin bad++; $display("FAIL busy_valid got=0 want=1"); end
    total++; if (bus_if.state_o !== exp) begin bad++; $display("FAIL busy_state got=%h want=%h", bus_if.state_o, exp); end
  endtask

  task automatic test_back_to_back();
    type_state s, exp;
    logic m;
    int low;
    m = 1'b0;
    s = rand_state();
    exp = ref_perm(s, 0);
    drive_accept(s, m);
    for (int n = 0; n < 4; n++) begin
      low = 0;
      for (int j = 0; j < lat_of(m); j++) begin
        if (bus_if.valid_o === 1'b0) low++;
        tick();
      end
      total++; if (low !== lat_of(m)) begin bad++; $display("FAIL b2b_low n=%0d got=%0d want=%0d", n, low, lat_of(m)); end
      total++; if (bus_if.valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid n=%0d got=0 want=1", n); end
      total++; if (bus_if.state_o !== exp) begin bad++; $display("FAIL b2b_state n=%0d got=%h want=%h", n, bus_if.state_o, exp); end
      if (n < 3) begin
        m = ~m;
        s = rand_state();
        exp = ref_perm(s, m ? 6 : 0);
        drive_accept(s, m);
      end
    end
  endtask

  task automatic test_mid_reset();
    type_state s, exp;
    int j;
    s = rand_state();
    drive_accept(s, 1'b0);
    j = 0;
    while (j * STEP < 7) begin
      tick();
      j++;
    end
    #2;
    rstn = 1'b0;
    #1;
    total++; if ({bus_if.ready_o, bus_if.valid_o} !== 2'b10) begin bad++; $display("FAIL rst_flags got=%b want=10", {bus_if.ready_o, bus_if.valid_o}); end
    total++; if (bus_if.state_o !== 320'h0) begin bad++; $display("FAIL rst_state got=%h want=0", bus_if.state_o); end
    total++; if (bus_if.round_o !== 4'd0) begin bad++; $display("FAIL rst_round got=%0d want=0", bus_if.round_o); end
    tick();
    rstn = 1'b1;
    tick();
    total++; if (bus_if.valid_o !== 1'b0 || bus_if.ready_o !== 1'b1) begin bad++; $display("FAIL rst_idle valid=%0b ready=%0b want 0/1", bus_if.valid_o, bus_if.ready_o); end
    s = rand_state();
    exp = ref_perm(s, 6);
    drive_accept(s, 1'b1);
    repeat (lat_of(1'b1)) tick();
    total++; if (bus_if.valid_o !== 1'b1) begin bad++; $display("FAIL rst_after_valid got=0 want=1"); end
    total++; if (bus_if.state_o !== exp) begin bad++; $display("FAIL rst_after_state got=%h want=%h", bus_if.state_o, exp); end
  endtask

  initial begin
    bus_if.start_i = 1'b0;
    bus_if.mode_i  = 1'b0;
    bus_if.state_i = '0;
    test_reset();
    test_p12_kat();
    test_p6();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
